// File: rtl/control_unit.sv
// control_unit -- hard-wired Moore controller for the single-bus datapath.
//
// Sequences every instruction through a common fetch (T0-T2), a decode step
// (T3) and up to four execute steps (T4-T7), one control step per clock.
// Outputs are decoded combinationally from the registered state, the opcode
// and con_ff, so they fall to zero the instant clr is asserted.
//
// Ports:
//   clk             rising-edge clock
//   clr             asynchronous active-low reset
//   ir[31:0]        instruction register, opcode in ir[31:27]
//   con_ff          branch condition flag, consulted only in br T6
//   enable[31:0]    register load enables (18 Zin, 19 Yin, 20 PCin, 21 MDRin,
//                   24 IRin, 25 MARin, 27 CONin)
//   busSelect[31:0] one-hot bus source (0 regfile, 19 ZLo, 20 PC, 21 MDR, 23 C)
//   Control_Signals ALU operation code, 0 when unused
//   Gra/Grb/Grc/Rin/Rout/BAout  register-file selects and strobes
//   MD_Read         MDR input mux (1 = memory, 0 = bus)
//   ReadRAM/WriteRAM memory strobes
//   run             high while executing, low in reset and after halt
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic [4:0]  Control_Signals,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        MD_Read,
  output logic        ReadRAM,
  output logic        WriteRAM,
  output logic        run
);

  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_OR  = 5'd4;
  localparam logic [4:0] ALU_INC = 5'd14;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  localparam int EN_Z   = 18;
  localparam int EN_Y   = 19;
  localparam int EN_PC  = 20;
  localparam int EN_MDR = 21;
  localparam int EN_IR  = 24;
  localparam int EN_MAR = 25;
  localparam int EN_CON = 27;

  localparam int B_RF  = 0;
  localparam int B_ZLO = 19;
  localparam int B_PC  = 20;
  localparam int B_MDR = 21;
  localparam int B_C   = 23;

  logic [3:0] state_q, state_d;
  logic [4:0] opcode_q, opcode_d;
  logic [4:0] op_s;
  logic       unused_ir_s;

  // Only the opcode field is decoded; operand fields go straight to the datapath.
  assign unused_ir_s = ^ir[26:0];

  // ALU code for the four register-register operations.
  function automatic logic [4:0] alu_code(input logic [4:0] op);
    logic [4:0] code;
    case (op)
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  // Decode uses ir directly in T3 (the opcode register is not loaded yet),
  // and the latched copy afterwards so ir may change during execute.
  always_comb begin
    if (state_q == S_T3) begin
      op_s = ir[31:27];
    end else begin
      op_s = opcode_q;
    end
    opcode_d = op_s;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = S_RST;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2:  state_d = S_T3;
      S_T3: begin
        case (op_s)
          OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_BR:  state_d = S_T4;
          OP_HALT:         state_d = S_HALT;
          default:         state_d = S_T0;   // jr, nop and undefined opcodes
        endcase
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        case (op_s)
          OP_LD, OP_ST, OP_BR: state_d = S_T6;
          default:             state_d = S_T0;
        endcase
      end
      S_T6: begin
        case (op_s)
          OP_LD, OP_ST: state_d = S_T7;
          default:      state_d = S_T0;
        endcase
      end
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // State and opcode registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_RST;
      opcode_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // run is purely a function of state: low in RST and HALT.
  assign run = (state_q >= S_T0) && (state_q <= S_T7);

  // Control-step decode.
  always_comb begin
    enable          = 32'd0;
    busSelect       = 32'd0;
    Control_Signals = 5'd0;
    Gra             = 1'b0;
    Grb             = 1'b0;
    Grc             = 1'b0;
    Rin             = 1'b0;
    Rout            = 1'b0;
    BAout           = 1'b0;
    MD_Read         = 1'b0;
    ReadRAM         = 1'b0;
    WriteRAM        = 1'b0;
    case (state_q)
      S_T0: begin
        busSelect[B_PC]  = 1'b1;
        enable[EN_MAR]   = 1'b1;
        Control_Signals  = ALU_INC;
        enable[EN_Z]     = 1'b1;
      end
      S_T1: begin
        busSelect[B_ZLO] = 1'b1;
        enable[EN_PC]    = 1'b1;
        MD_Read          = 1'b1;
        ReadRAM          = 1'b1;
        enable[EN_MDR]   = 1'b1;
      end
      S_T2: begin
        busSelect[B_MDR] = 1'b1;
        enable[EN_IR]    = 1'b1;
      end
      S_T3: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            Grb             = 1'b1;
            Rout            = 1'b1;
            busSelect[B_RF] = 1'b1;
            enable[EN_Y]    = 1'b1;
          end
          // BAout still sources the bus from the register file, reading R0 as 0.
          OP_LDI, OP_LD, OP_ST: begin
            Grb             = 1'b1;
            BAout           = 1'b1;
            busSelect[B_RF] = 1'b1;
            enable[EN_Y]    = 1'b1;
          end
          OP_BR: begin
            Gra             = 1'b1;
            Rout            = 1'b1;
            busSelect[B_RF] = 1'b1;
            enable[EN_CON]  = 1'b1;
          end
          OP_JR: begin
            Gra             = 1'b1;
            Rout            = 1'b1;
            busSelect[B_RF] = 1'b1;
            enable[EN_PC]   = 1'b1;
          end
          default: begin
          end
        endcase
      end
      S_T4: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            Grc             = 1'b1;
            Rout            = 1'b1;
            busSelect[B_RF] = 1'b1;
            Control_Signals = alu_code(op_s);
            enable[EN_Z]    = 1'b1;
          end
          OP_ADDI, OP_LDI, OP_LD, OP_ST: begin
            busSelect[B_C]  = 1'b1;
            Control_Signals = ALU_ADD;
            enable[EN_Z]    = 1'b1;
          end
          OP_BR: begin
            busSelect[B_PC] = 1'b1;
            enable[EN_Y]    = 1'b1;
          end
          default: begin
          end
        endcase
      end
      S_T5: begin
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: begin
            busSelect[B_ZLO] = 1'b1;
            Gra              = 1'b1;
            Rin              = 1'b1;
          end
          OP_LD, OP_ST: begin
            busSelect[B_ZLO] = 1'b1;
            enable[EN_MAR]   = 1'b1;
          end
          OP_BR: begin
            busSelect[B_C]  = 1'b1;
            Control_Signals = ALU_ADD;
            enable[EN_Z]    = 1'b1;
          end
          default: begin
          end
        endcase
      end
      S_T6: begin
        case (op_s)
          OP_LD: begin
            MD_Read        = 1'b1;
            ReadRAM        = 1'b1;
            enable[EN_MDR] = 1'b1;
          end
          OP_ST: begin
            Gra             = 1'b1;
            Rout            = 1'b1;
            busSelect[B_RF] = 1'b1;
            enable[EN_MDR]  = 1'b1;
          end
          OP_BR: begin
            busSelect[B_ZLO] = 1'b1;
            if (con_ff) begin
              enable[EN_PC] = 1'b1;
            end else begin
              enable[EN_PC] = 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
      S_T7: begin
        case (op_s)
          OP_LD: begin
            busSelect[B_MDR] = 1'b1;
            Gra              = 1'b1;
            Rin              = 1'b1;
          end
          OP_ST: WriteRAM = 1'b1;
          default: begin
          end
        endcase
      end
      default: begin
      end
    endcase
  end

endmodule
